// File: rtl/zorro_pkg.sv
// zorro_pkg: shared state encoding and defaults for the Zorro III master cycle sequencer.
package zorro_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        STRB  = 3'd2,
        DATA  = 3'd3,
        TERM  = 3'd4,
        RECOV = 3'd5
    } state_t;

    localparam logic [3:0] DS_IDLE            = 4'hF;
    localparam int         DEF_SETUP_CYCLES   = 1;
    localparam int         DEF_TIMEOUT_CYCLES = 64;

endpackage

// File: rtl/zorro_cycle_timer.sv
// zorro_cycle_timer: state-residency counter, cleared whenever disabled, flags the terminal count.
module zorro_cycle_timer #(
    parameter int W    = 1,
    parameter int LAST = 0
) (
    input  logic CLK,
    input  logic RESET_n,
    input  logic en,
    output logic done
);

    logic [W-1:0] count;

    assign done = count == W'(LAST);

    // holding at the terminal value keeps the counter from wrapping
    always_ff @(posedge CLK) begin
        if (!RESET_n || !en)
            count <= '0;
        else if (!done)
            count <= count + 1'b1;
    end

endmodule

// File: rtl/zorro_master_cycle_ctrl.sv
// zorro_master_cycle_ctrl: sequences Zorro III master strobes (address, FCS_n, DOE/DS_n)
// and reports ACK on DTACK_n or ERR on BERR_n/timeout.
module zorro_master_cycle_ctrl
    import zorro_pkg::*;
#(
    parameter int SETUP_CYCLES   = DEF_SETUP_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic       CLK,
    input  logic       RESET_n,
    input  logic       MYBUS_n,
    input  logic       REQ,
    input  logic       RW,
    input  logic [3:0] BE,
    input  logic       DTACK_n,
    input  logic       BERR_n,
    output logic       ADDR_OE,
    output logic       FCS_n,
    output logic       DOE,
    output logic [3:0] DS_n,
    output logic       READ,
    output logic       ACK,
    output logic       ERR,
    output logic       BUSY
);

    state_t     state, state_nx;
    logic [3:0] be_q;
    logic       setup_done, tmo_done, err_nx;

    zorro_cycle_timer #(.W($clog2(SETUP_CYCLES + 1)), .LAST(SETUP_CYCLES - 1)) u_setup (
        .CLK     (CLK),
        .RESET_n (RESET_n),
        .en      (state == ADDR),
        .done    (setup_done)
    );

    zorro_cycle_timer #(.W($clog2(TIMEOUT_CYCLES)), .LAST(TIMEOUT_CYCLES - 1)) u_timeout (
        .CLK     (CLK),
        .RESET_n (RESET_n),
        .en      (state == DATA),
        .done    (tmo_done)
    );

    always_comb begin
        state_nx = state;
        err_nx   = 1'b0;
        case (state)
            IDLE:  state_nx = (REQ && !MYBUS_n) ? ADDR : IDLE;
            ADDR:  state_nx = (MYBUS_n || !REQ) ? IDLE : setup_done ? STRB : ADDR;
            STRB:  state_nx = DATA;
            DATA: begin
                // BERR_n outranks DTACK_n; a timeout only matters when neither arrived
                state_nx = (!BERR_n || !DTACK_n || tmo_done) ? TERM : DATA;
                err_nx   = !BERR_n || DTACK_n;
            end
            TERM:  state_nx = RECOV;
            RECOV: state_nx = (DTACK_n && BERR_n) ? IDLE : RECOV;
            default: state_nx = IDLE;
        endcase
    end

    // outputs are flopped from the next state so they change in step with the state register
    always_ff @(posedge CLK) begin
        if (!RESET_n) begin
            state   <= IDLE;
            be_q    <= '0;
            ADDR_OE <= 1'b0;
            FCS_n   <= 1'b1;
            DOE     <= 1'b0;
            DS_n    <= DS_IDLE;
            READ    <= 1'b1;
            ACK     <= 1'b0;
            ERR     <= 1'b0;
            BUSY    <= 1'b0;
        end else begin
            state   <= state_nx;
            if (state == IDLE && state_nx == ADDR) begin
                READ <= RW;
                be_q <= BE;
            end
            ADDR_OE <= state_nx inside {ADDR, STRB, DATA};
            FCS_n   <= !(state_nx inside {STRB, DATA});
            DOE     <= state_nx == DATA;
            DS_n    <= (state_nx == DATA) ? ~be_q : DS_IDLE;
            ACK     <= state_nx == TERM && !err_nx;
            ERR     <= state_nx == TERM && err_nx;
            BUSY    <= state_nx != IDLE;
        end
    end

endmodule
